// File: rtl/bsg_fpu_pkg.sv
// Shared FCLASS definitions: mask bit positions, decoded-flag record,
// and the flag-to-mask classification used by the pipeline's second stage.
package bsg_fpu_pkg;

   localparam int fclass_ninf_gp  = 0;
   localparam int fclass_nnorm_gp = 1;
   localparam int fclass_nsub_gp  = 2;
   localparam int fclass_nzero_gp = 3;
   localparam int fclass_pzero_gp = 4;
   localparam int fclass_psub_gp  = 5;
   localparam int fclass_pnorm_gp = 6;
   localparam int fclass_pinf_gp  = 7;
   localparam int fclass_snan_gp  = 8;
   localparam int fclass_qnan_gp  = 9;
   localparam int fclass_width_gp = 10;

   typedef struct packed {
      logic sign;
      logic exp_ones;
      logic exp_zero;
      logic man_zero;
      logic man_msb;
      logic nanbox_bad;
   } bsg_fpu_fclass_flags_s;

   // One-hot FCLASS mask from decoded flags. A badly boxed single is treated
   // as the canonical quiet NaN, so it wins over every other field.
   function automatic logic [fclass_width_gp-1:0] bsg_fpu_fclass_mask(
      input bsg_fpu_fclass_flags_s f
   );
      logic [fclass_width_gp-1:0] m;
      m = '0;
      if (f.nanbox_bad) begin
         m[fclass_qnan_gp] = 1'b1;
      end else if (f.exp_ones) begin
         if (f.man_zero)
            m[f.sign ? fclass_ninf_gp : fclass_pinf_gp] = 1'b1;
         else
            m[f.man_msb ? fclass_qnan_gp : fclass_snan_gp] = 1'b1;
      end else if (f.exp_zero) begin
         if (f.man_zero)
            m[f.sign ? fclass_nzero_gp : fclass_pzero_gp] = 1'b1;
         else
            m[f.sign ? fclass_nsub_gp : fclass_psub_gp] = 1'b1;
      end else begin
         m[f.sign ? fclass_nnorm_gp : fclass_pnorm_gp] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/bsg_fpu_fclass_decode.sv
// Combinational field decode of an IEEE-754 value (e_p exponent bits,
// m_p mantissa bits) into the flags consumed by the FCLASS pipeline.
// NaN-box status depends on the container, so it is left to the caller.
module bsg_fpu_fclass_decode
   import bsg_fpu_pkg::*;
#(
   parameter int e_p = 8,
   parameter int m_p = 23
) (
   input  logic [e_p+m_p:0]        a_i,
   output bsg_fpu_fclass_flags_s   flags_o
);

   assign flags_o.sign       = a_i[e_p+m_p];
   assign flags_o.exp_ones   = &a_i[e_p+m_p-1:m_p];
   assign flags_o.exp_zero   = ~|a_i[e_p+m_p-1:m_p];
   assign flags_o.man_zero   = ~|a_i[m_p-1:0];
   assign flags_o.man_msb    = a_i[m_p-1];
   assign flags_o.nanbox_bad = 1'b0;

endmodule

// File: rtl/bsg_fpu_fclass_pipe.sv
// Two-stage pipelined FCLASS unit (single or double precision operands).
// Stage 1 holds decoded flags, stage 2 holds the 64-bit zero-extended mask.
// Input side is valid/ready, output side is valid/yumi.
// Optional build macro BSG_FPU_FCLASS_STATS_EN adds a saturating count of
// dequeued sNaN results on snan_count_o.
module bsg_fpu_fclass_pipe
   import bsg_fpu_pkg::*;
#(
   parameter int nanbox_check_p = 1
`ifdef BSG_FPU_FCLASS_STATS_EN
   , parameter int stats_width_p = 16
`endif
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        v_i,
   output logic        ready_o,
   input  logic [63:0] a_i,
   input  logic        dp_i,
   output logic        v_o,
   output logic [63:0] class_o,
   input  logic        yumi_i
`ifdef BSG_FPU_FCLASS_STATS_EN
   , output logic [stats_width_p-1:0] snan_count_o
`endif
);

   bsg_fpu_fclass_flags_s             w_dec_flags [2];
   bsg_fpu_fclass_flags_s             w_flags;
   logic                              w_nanbox_bad;
   logic                              w_adv2;
   logic                              w_accept;
   logic                              w_deq;

   logic                              r_v1;
   bsg_fpu_fclass_flags_s             r_flags;
   logic                              r_v_o;
   logic [fclass_width_gp-1:0]        r_class;

   // Index 0 decodes single precision (8,23), index 1 double precision (11,52).
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dec
         localparam int lp_e = (gi == 0) ? 8  : 11;
         localparam int lp_m = (gi == 0) ? 23 : 52;
         bsg_fpu_fclass_decode #(
            .e_p (lp_e),
            .m_p (lp_m)
         ) u_dec (
            .a_i     (a_i[lp_e+lp_m:0]),
            .flags_o (w_dec_flags[gi])
         );
      end
   endgenerate

   // A single is only legitimate when its upper word is all ones.
   assign w_nanbox_bad = (nanbox_check_p != 0) && !dp_i && (a_i[63:32] != 32'hFFFF_FFFF);

   // Select the precision's decode and attach the NaN-box verdict.
   always_comb begin
      w_flags            = w_dec_flags[dp_i];
      w_flags.nanbox_bad = w_nanbox_bad;
   end

   // Stage 2 loads whenever it is empty or being drained this cycle.
   assign w_adv2   = r_v1 & (~r_v_o | yumi_i);
   assign ready_o  = ~reset_i & (~r_v1 | w_adv2);
   assign w_accept = v_i & ready_o;
   assign w_deq    = r_v_o & yumi_i;

   // Stage 1 valid: refilled from the input whenever the slot is free or moving on.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_v1 <= 1'b0;
      else if (ready_o)
         r_v1 <= v_i;
   end

   // Stage 1 flags: captured only on a completed input handshake.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_flags <= '0;
      else if (w_accept)
         r_flags <= w_flags;
   end

   // Stage 2: classify stage-1 flags on advance, drop valid on a bare dequeue.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_v_o   <= 1'b0;
         r_class <= '0;
      end else if (w_adv2) begin
         r_v_o   <= 1'b1;
         r_class <= bsg_fpu_fclass_mask(r_flags);
      end else if (w_deq) begin
         r_v_o   <= 1'b0;
      end
   end

   assign v_o     = r_v_o;
   assign class_o = {{(64-fclass_width_gp){1'b0}}, r_class};

`ifdef BSG_FPU_FCLASS_STATS_EN
   logic [stats_width_p-1:0] r_snan_count;

   // Saturating count of sNaN results actually taken by the consumer.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_snan_count <= '0;
      else if (w_deq && r_class[fclass_snan_gp] && !(&r_snan_count))
         r_snan_count <= r_snan_count + 1'b1;
   end

   assign snan_count_o = r_snan_count;
`endif

endmodule
